// File: rtl/axi_lite_uart_regs.sv
// ---------------------------------------------------------------------------
// axi_lite_uart_regs
//
// AXI4-Lite write-only responder that holds the UART transmitter's control
// state. AW and W are accepted independently and in either order. A write
// commits on the edge where both channels are available, and it is then
// answered on B. The B response waits for s_bready for as long as needed.
//
// Register map (byte address, word aligned, addr[1:0] ignored):
//   0x00 CTRL     [1:0] parity_sel, [2] tx_en, [4:3] irq enables (RW)
//   0x04 TX_DATA  byte 0, write-only, launches a transmit
//   0x08 BAUD_DIV [15:0] RW
//   0x20 STATUS   [0] tx_done, [1] rx_overrun, sticky, write-1-to-clear
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   s_aw*, s_w*, s_b*               AXI4-Lite write channels
//   tx_busy, tx_done_evt,
//   rx_overrun_evt                  status inputs from the UART
//   parity_sel, tx_en, baud_div     control outputs to the transmitter
//   tx_data, tx_start               byte to send and its one-cycle launch
//   status, irq                     sticky status and registered interrupt
//
// Handshake: a channel transfers on the rising edge where valid and ready
// are both 1. The master keeps valid and payload stable until then. Each
// ready depends only on registered state, never on the matching valid.
// ---------------------------------------------------------------------------
module axi_lite_uart_regs #(
    parameter int          ADDR_W   = 32,
    parameter logic [15:0] BAUD_RST = 16'd434
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic              tx_busy,
    input  logic              tx_done_evt,
    input  logic              rx_overrun_evt,
    output logic [1:0]        parity_sel,
    output logic              tx_en,
    output logic [15:0]       baud_div,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    output logic [1:0]        status,
    output logic              irq
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

    localparam int WA_W = ADDR_W - 2;
    localparam logic [WA_W-1:0] WA_CTRL   = WA_W'(0);
    localparam logic [WA_W-1:0] WA_TXDATA = WA_W'(1);
    localparam logic [WA_W-1:0] WA_BAUD   = WA_W'(2);
    localparam logic [WA_W-1:0] WA_STATUS = WA_W'(8);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [0:0]      state_q, state_d;
    logic            aw_held_q, aw_held_d;
    logic            w_held_q, w_held_d;
    logic [WA_W-1:0] addr_q, addr_d;
    logic [15:0]     wdata_q, wdata_d;     // only the low 16 bits map to state
    logic [1:0]      wstrb_q, wstrb_d;
    logic [4:0]      ctrl_q, ctrl_d;
    logic [15:0]     baud_q, baud_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic [1:0]      status_q, status_d;
    logic            irq_q, irq_d;
    logic [1:0]      bresp_q, bresp_d;
    // Held low through reset so neither channel looks ready while rst is high.
    logic            rdy_en_q, rdy_en_d;

    logic            aw_hs, w_hs, commit;
    logic [WA_W-1:0] c_addr;
    logic [15:0]     c_data;
    logic [1:0]      c_strb;

    logic unused_bits;
    assign unused_bits = ^{s_awaddr[1:0], s_wdata[31:16], s_wstrb[3:2]};

    assign s_awready = rdy_en_q & (state_q == ST_IDLE) & ~aw_held_q;
    assign s_wready  = rdy_en_q & (state_q == ST_IDLE) & ~w_held_q;
    assign s_bvalid  = (state_q == ST_RESP);
    assign s_bresp   = bresp_q;

    assign parity_sel = ctrl_q[1:0];
    assign tx_en      = ctrl_q[2];
    assign baud_div   = baud_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign status     = status_q;
    assign irq        = irq_q;

    always_comb begin
        aw_hs  = s_awvalid & s_awready;
        w_hs   = s_wvalid & s_wready;
        // A channel is available if held from an earlier edge or handshaking now.
        c_addr = aw_held_q ? addr_q : s_awaddr[ADDR_W-1:2];
        c_data = w_held_q ? wdata_q : s_wdata[15:0];
        c_strb = w_held_q ? wstrb_q : s_wstrb[1:0];
        commit = (state_q == ST_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);

        state_d    = state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        ctrl_d     = ctrl_q;
        baud_d     = baud_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        status_d   = status_q;
        bresp_d    = bresp_q;
        rdy_en_d   = 1'b1;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            addr_d    = s_awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_wdata[15:0];
            wstrb_d  = s_wstrb[1:0];
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            state_d   = ST_RESP;
            bresp_d   = RESP_OKAY;
            case (c_addr)
                WA_CTRL: begin
                    if (c_strb[0]) ctrl_d = c_data[4:0];
                end
                WA_TXDATA: begin
                    // Without byte 0 there is nothing to send: silently OKAY.
                    if (c_strb[0]) begin
                        if (tx_busy || !ctrl_q[2]) begin
                            bresp_d = RESP_SLVERR;
                        end else begin
                            tx_data_d  = c_data[7:0];
                            tx_start_d = 1'b1;
                        end
                    end
                end
                WA_BAUD: begin
                    if (c_strb[0]) baud_d[7:0]  = c_data[7:0];
                    if (c_strb[1]) baud_d[15:8] = c_data[15:8];
                end
                WA_STATUS: begin
                    if (c_strb[0]) status_d = status_q & ~c_data[1:0];
                end
                default: bresp_d = RESP_SLVERR;
            endcase
        end

        if (state_q == ST_RESP && s_bready) state_d = ST_IDLE;

        // Event set is applied after any clear so a same-cycle event survives.
        status_d = status_d | {rx_overrun_evt, tx_done_evt};
        irq_d    = |(status_q & ctrl_q[4:3]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            ctrl_q     <= '0;
            baud_q     <= BAUD_RST;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            status_q   <= '0;
            irq_q      <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            status_q   <= status_d;
            irq_q      <= irq_d;
            bresp_q    <= bresp_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_uart_regs.sv
// Testbench for axi_lite_uart_regs: directed scenarios followed by
// randomized writes checked against a register-map level reference model.
module tb_axi_lite_uart_regs;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_awaddr;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid, s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic        tx_busy, tx_done_evt, rx_overrun_evt;
  logic [1:0]  parity_sel;
  logic        tx_en;
  logic [15:0] baud_div;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [1:0]  status;
  logic        irq;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  axi_lite_uart_regs #(.ADDR_W(ADDR_W), .BAUD_RST(16'd434)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .tx_busy(tx_busy), .tx_done_evt(tx_done_evt), .rx_overrun_evt(rx_overrun_evt),
    .parity_sel(parity_sel), .tx_en(tx_en), .baud_div(baud_div),
    .tx_data(tx_data), .tx_start(tx_start), .status(status), .irq(irq)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];   // expected B responses, in commit order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [4:0]  m_ctrl;
  logic [15:0] m_baud;
  logic [7:0]  m_txd;
  logic [1:0]  m_status;

  task automatic model_reset();
    m_ctrl = '0; m_baud = 16'd434; m_txd = '0; m_status = '0;
    exp_q.delete();
  endtask

  task automatic model_commit(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic busy, input logic [1:0] evt,
                              output logic [1:0] resp, output logic start);
    logic [29:0] word;
    word = addr[31:2];
    resp = 2'b00;
    start = 1'b0;
    if (word == 30'd0) begin
      if (strb[0]) m_ctrl = data[4:0];
    end else if (word == 30'd1) begin
      if (strb[0]) begin
        if (busy || !m_ctrl[2]) resp = 2'b10;
        else begin m_txd = data[7:0]; start = 1'b1; end
      end
    end else if (word == 30'd2) begin
      if (strb[0]) m_baud[7:0] = data[7:0];
      if (strb[1]) m_baud[15:8] = data[15:8];
    end else if (word == 30'd8) begin
      if (strb[0]) m_status = m_status & ~data[1:0];
    end else begin
      resp = 2'b10;
    end
    m_status = m_status | evt;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".parity"}, parity_sel, m_ctrl[1:0]);
    check({tag, ".tx_en"}, tx_en, m_ctrl[2]);
    check({tag, ".baud"}, baud_div, m_baud);
    check({tag, ".tx_data"}, tx_data, m_txd);
    check({tag, ".status"}, status, m_status);
    check({tag, ".irq"}, irq, |(m_status & m_ctrl[4:3]));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".parity"}, parity_sel, 0);
    check({tag, ".tx_en"}, tx_en, 0);
    check({tag, ".baud"}, baud_div, 16'd434);
    check({tag, ".tx_data"}, tx_data, 0);
    check({tag, ".tx_start"}, tx_start, 0);
    check({tag, ".status"}, status, 0);
    check({tag, ".irq"}, irq, 0);
    check({tag, ".bvalid"}, s_bvalid, 0);
    check({tag, ".bresp"}, s_bresp, 0);
    check({tag, ".awready"}, s_awready, 0);
    check({tag, ".wready"}, s_wready, 0);
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic busy, input logic [1:0] evt);
    bit aw_done, w_done, aw_go, w_go, fire;
    int cyc;
    logic [1:0] resp, got;
    logic start;
    aw_done = 0; w_done = 0; cyc = 0; start = 1'b0;
    tx_busy = busy;
    while (!(aw_done && w_done)) begin
      s_awvalid = !aw_done && (cyc >= aw_dly);
      s_awaddr  = addr;
      s_wvalid  = !w_done && (cyc >= w_dly);
      s_wdata   = data;
      s_wstrb   = strb;
      #1;
      check("awready_idle", s_awready, !aw_done);
      check("wready_idle", s_wready, !w_done);
      aw_go = s_awvalid && s_awready;
      w_go  = s_wvalid && s_wready;
      fire  = (aw_done || aw_go) && (w_done || w_go);
      tx_done_evt    = fire ? evt[0] : 1'b0;
      rx_overrun_evt = fire ? evt[1] : 1'b0;
      @(posedge clk);
      aw_done = aw_done || aw_go;
      w_done  = w_done || w_go;
      if (fire) begin
        model_commit(addr, data, strb, busy, evt, resp, start);
        exp_q.push_back(resp);
      end
      @(negedge clk);
      tx_done_evt = 1'b0; rx_overrun_evt = 1'b0;
      cyc++;
      if (cyc > 40) begin
        check("write_timeout", 0, 1);
        s_awvalid = 0; s_wvalid = 0;
        return;
      end
    end
    s_awvalid = 0; s_wvalid = 0;
    check("bvalid_after_commit", s_bvalid, 1);
    check("tx_start_pulse", tx_start, start);
    check("tx_data_commit", tx_data, m_txd);
    got = s_bresp;
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check("bvalid_hold", s_bvalid, 1);
      check("bresp_hold", s_bresp, got);
      check("awready_resp", s_awready, 0);
      check("wready_resp", s_wready, 0);
      check("tx_start_once", tx_start, 0);
    end
    if (exp_q.size() > 0) check("bresp", got, exp_q.pop_front());
    else check("bresp_queue_empty", 0, 1);
    s_bready = 1;
    @(posedge clk);
    @(negedge clk);
    s_bready = 0;
    check("bvalid_drop", s_bvalid, 0);
    check("awready_back", s_awready, 1);
    check("wready_back", s_wready, 1);
    check("tx_start_low", tx_start, 0);
    check_regs("post_write");
  endtask

  task automatic pulse_evt(input logic [1:0] evt);
    tx_done_evt = evt[0]; rx_overrun_evt = evt[1];
    @(posedge clk);
    m_status = m_status | evt;
    @(negedge clk);
    tx_done_evt = 0; rx_overrun_evt = 0;
    check("evt_status", status, m_status);
    @(negedge clk);
    check("evt_irq", irq, |(m_status & m_ctrl[4:3]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] bases [8];
    logic [31:0] a, d;
    bases[0] = 32'h00; bases[1] = 32'h04; bases[2] = 32'h08; bases[3] = 32'h20;
    bases[4] = 32'h0C; bases[5] = 32'h10; bases[6] = 32'h24; bases[7] = 32'h8000_0008;

    rst = 1; s_awaddr = 0; s_awvalid = 0; s_wdata = 0; s_wstrb = 0; s_wvalid = 0;
    s_bready = 0; tx_busy = 0; tx_done_evt = 0; rx_overrun_evt = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 0;
    @(negedge clk);
    check("awready_after_rst", s_awready, 1);
    check("wready_after_rst", s_wready, 1);

    // Enable transmitter, then launch 0xA5.
    do_write(32'h00, 32'h04, 4'hF, 0, 0, 0, 0, 2'b00);
    do_write(32'h04, 32'hA5, 4'hF, 0, 0, 0, 0, 2'b00);
    check("tx_data_a5", tx_data, 8'hA5);

    // W three cycles ahead of AW, low byte only.
    do_write(32'h08, 32'h0000_1B20, 4'h1, 3, 0, 0, 0, 2'b00);
    check("baud_low_byte", baud_div, 16'h0120);

    // Error cases leave state untouched.
    do_write(32'h0C, 32'h44, 4'hF, 0, 0, 1, 0, 2'b00);
    do_write(32'h04, 32'h44, 4'hF, 0, 2, 0, 1, 2'b00);
    check("tx_data_kept", tx_data, 8'hA5);

    // Sticky status, interrupt, and set-beats-clear.
    pulse_evt(2'b01);
    do_write(32'h00, 32'h08, 4'hF, 0, 0, 0, 0, 2'b00);
    check("status_01", status, 2'b01);
    check("irq_on", irq, 1);
    do_write(32'h20, 32'h01, 4'hF, 1, 0, 0, 0, 2'b01);
    check("status_set_wins", status, 2'b01);
    do_write(32'h20, 32'h01, 4'hF, 0, 0, 0, 0, 2'b00);
    check("status_cleared", status, 2'b00);
    check("irq_off", irq, 0);

    // Long B backpressure.
    do_write(32'h08, 32'h0000_3C3C, 4'h3, 0, 0, 10, 0, 2'b00);

    // Reset with W held.
    s_wvalid = 1; s_wdata = 32'h55; s_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    s_wvalid = 0;
    check("wready_held", s_wready, 0);
    check("awready_open", s_awready, 1);
    rst = 1;
    #1;
    model_reset();
    check_reset_vals("mid_reset");
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("awready_rerst", s_awready, 1);
    check("wready_rerst", s_wready, 1);
    do_write(32'h00, 32'h17, 4'hF, 0, 1, 0, 0, 2'b00);
    do_write(32'h04, 32'h3C, 4'h1, 0, 0, 0, 0, 2'b00);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      a = bases[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h00;
      if (a[31:2] == 30'd0 && $urandom_range(0, 1) == 1) d[2] = 1'b1;
      do_write(a, d, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 3) == 0),
               ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      if ($urandom_range(0, 5) == 0) pulse_evt(2'($urandom_range(1, 3)));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
